score_display_ctrl: RTL



---
 rtl/display_pkg.sv | 23 ++
 rtl/score_display_ctrl_dd_step.sv | 32 +++
 rtl/score_display_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared constants for the score display sequencer: digit code width,
// blank code, FSM state encoding and a helper for the display range.
package display_pkg;

    localparam int DIG_W = 4;
    localparam logic [DIG_W-1:0] BLANK_CODE = 4'd10;

    // State encoding kept as plain constants for legacy tool compatibility.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    // Largest value that fits on n decimal digits (10^n - 1).
    function automatic int unsigned disp_max(input int n);
        int unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/score_display_ctrl_dd_step.sv
// One combinational double-dabble iteration: add 3 to every BCD nibble that
// is 5 or more, then shift the BCD/binary pair left by one bit.
module dd_step
    import display_pkg::*;
#(
    parameter int N_DIG = 4,
    parameter int BIN_W = 14
) (
    input  logic [DIG_W*N_DIG-1:0] bcd_i,
    input  logic [BIN_W-1:0]       bin_i,
    output logic [DIG_W*N_DIG-1:0] bcd_o,
    output logic [BIN_W-1:0]       bin_o
);

    localparam int BCD_W = DIG_W * N_DIG;

    logic [BCD_W-1:0] adj;

    // Nibble correction followed by the shift; the BCD MSB shifted out is
    // always zero because inputs are saturated to the display range.
    always_comb begin
        adj = bcd_i;
        for (int d = 0; d < N_DIG; d++) begin
            if (bcd_i[d*DIG_W +: DIG_W] >= 4'd5) begin
                adj[d*DIG_W +: DIG_W] = bcd_i[d*DIG_W +: DIG_W] + 4'd3;
            end
        end
        bcd_o = BCD_W'({adj, bin_i[BIN_W-1]});
        bin_o = bin_i << 1;
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Score display sequencer: saturates a binary value to the display range,
// converts it to BCD with a multi-cycle double-dabble and presents one
// decoder code per digit, optionally blanking leading zeros.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for atualizar; ocupado low
// ST_CONV   | one double-dabble step per clock, down-counter tracks steps
// ST_FINISH | publish blanked digits, pulse pronto, restart if pending
module score_display_ctrl
    import display_pkg::*;
#(
    parameter int N_DIG     = 4,
    parameter int BIN_W     = 14,
    parameter int ZERO_SUPR = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BIN_W-1:0]       valor,
    input  logic                   atualizar,
    output logic [DIG_W*N_DIG-1:0] digitos,
    output logic                   ocupado,
    output logic                   pronto,
    output logic                   overflow
);

    localparam int BCD_W            = DIG_W * N_DIG;
    localparam int unsigned MAX_INT = disp_max(N_DIG);
    localparam int MAX_W            = $clog2(MAX_INT + 1);
    localparam int CMP_W            = (BIN_W > MAX_W) ? BIN_W : MAX_W;
    localparam int CNT_W            = $clog2(BIN_W + 1);
    localparam logic [CMP_W-1:0] MAX_C = CMP_W'(MAX_INT);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             ovf_int_q, ovf_int_d;
    logic             pend_q, pend_d;
    logic [BCD_W-1:0] dig_q, dig_d;
    logic             ocup_q, ocup_d;
    logic             pronto_q, pronto_d;
    logic             ovf_out_q, ovf_out_d;

    logic [CMP_W-1:0] valor_ext;
    logic             ovf_in;
    logic [BIN_W-1:0] sat_val;
    logic [BCD_W-1:0] step_bcd;
    logic [BIN_W-1:0] step_bin;
    logic [BCD_W-1:0] blanked;

    // Range compare runs at the wider of the input and the display maximum.
    assign valor_ext = CMP_W'(valor);
    assign ovf_in    = (valor_ext > MAX_C);
    assign sat_val   = ovf_in ? BIN_W'(MAX_C) : valor;

    dd_step #(
        .N_DIG (N_DIG),
        .BIN_W (BIN_W)
    ) u_dd_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (step_bcd),
        .bin_o (step_bin)
    );

    // Leading-zero blanking: a digit is blanked only while every more
    // significant digit is zero; the units digit always shows.
    for (genvar i = 0; i < N_DIG; i++) begin : g_blank
        logic [DIG_W-1:0] nib;
        logic             seen_nz_above;
        assign nib = bcd_q[i*DIG_W +: DIG_W];
        if (i == N_DIG - 1) begin : g_top
            assign seen_nz_above = 1'b0;
        end else begin : g_lower
            assign seen_nz_above = |bcd_q[BCD_W-1:(i+1)*DIG_W];
        end
        if ((ZERO_SUPR != 0) && (i != 0)) begin : g_supr
            assign blanked[i*DIG_W +: DIG_W] =
                (!seen_nz_above && (nib == 4'd0)) ? BLANK_CODE : nib;
        end else begin : g_keep
            assign blanked[i*DIG_W +: DIG_W] = nib;
        end
    end

    // Next-state logic for the sequencer and its datapath.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        ovf_int_d = ovf_int_q;
        pend_d    = pend_q;
        dig_d     = dig_q;
        ocup_d    = ocup_q;
        pronto_d  = 1'b0;
        ovf_out_d = ovf_out_q;
        case (state_q)
            ST_IDLE: begin
                if (atualizar) begin
                    bcd_d     = '0;
                    bin_d     = sat_val;
                    ovf_int_d = ovf_in;
                    cnt_d     = CNT_W'(BIN_W);
                    ocup_d    = 1'b1;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d = step_bcd;
                bin_d = step_bin;
                cnt_d = cnt_q - CNT_W'(1);
                if (atualizar) begin
                    pend_d = 1'b1;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                dig_d     = blanked;
                ovf_out_d = ovf_int_q;
                pronto_d  = 1'b1;
                if (pend_q || atualizar) begin
                    pend_d    = 1'b0;
                    bcd_d     = '0;
                    bin_d     = sat_val;
                    ovf_int_d = ovf_in;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = ST_CONV;
                end else begin
                    ocup_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                pend_d  = 1'b0;
                ocup_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset mid-way
    // simply discards the conversion in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            ovf_int_q <= 1'b0;
            pend_q    <= 1'b0;
            dig_q     <= {N_DIG{BLANK_CODE}};
            ocup_q    <= 1'b0;
            pronto_q  <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            ovf_int_q <= ovf_int_d;
            pend_q    <= pend_d;
            dig_q     <= dig_d;
            ocup_q    <= ocup_d;
            pronto_q  <= pronto_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign digitos  = dig_q;
    assign ocupado  = ocup_q;
    assign pronto   = pronto_q;
    assign overflow = ovf_out_q;

endmodule
